// File: rtl/dmi_arbiter_if.sv
// rtl/dmi_arbiter_if.sv - upstream and downstream DMI handshake bundle for dmi_arbiter
interface dmi_arbiter_if #(
  parameter int NumReq = 2
);
  logic [NumReq-1:0]    req_valid_i;
  logic [NumReq-1:0]    req_ready_o;
  logic [NumReq*7-1:0]  req_addr_i;
  logic [NumReq*32-1:0] req_data_i;
  logic [NumReq*2-1:0]  req_op_i;
  logic [NumReq-1:0]    resp_valid_o;
  logic [NumReq-1:0]    resp_ready_i;
  logic [31:0]          resp_data_o;
  logic [1:0]           resp_resp_o;
  logic                 dmi_req_valid_o;
  logic                 dmi_req_ready_i;
  logic [6:0]           dmi_req_addr_o;
  logic [31:0]          dmi_req_data_o;
  logic [1:0]           dmi_req_op_o;
  logic                 dmi_resp_valid_i;
  logic                 dmi_resp_ready_o;
  logic [31:0]          dmi_resp_data_i;
  logic [1:0]           dmi_resp_resp_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
    input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_resp_o,
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_resp_ready_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_op_i, resp_ready_i,
    output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_resp_o,
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_resp_ready_o
  );
endinterface

// File: rtl/dmi_arbiter.sv
// rtl/dmi_arbiter.sv - round-robin DMI arbiter with one outstanding transaction and response watchdog
module dmi_arbiter #(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 1024,
  localparam int GrantW       = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmi_arbiter_if.slave      bus,
  output logic              busy_o,
  output logic [GrantW-1:0] grant_o,
  output logic              timeout_o,
  output logic [7:0]        stray_count_o
);

  localparam int WdW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [WdW-1:0] WdLast = (TimeoutCycles > 0) ? WdW'(TimeoutCycles - 1) : '0;

  typedef enum logic [1:0] {Idle, Req, Resp, ErrResp} state_e;

  state_e            state_q, state_d;
  logic [GrantW-1:0] rr_q, rr_d;
  logic [GrantW-1:0] grant_q, grant_d;
  logic [3:0]        orphan_q, orphan_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [7:0]        stray_q, stray_d;
  logic [6:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        op_q, op_d;

  logic              win_found;
  logic [GrantW-1:0] win_idx;
  logic [GrantW-1:0] rr_next;
  int                idx;
  int                nxt;
  logic              late_rsp;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= Idle;
      rr_q     <= '0;
      grant_q  <= '0;
      orphan_q <= '0;
      wd_q     <= '0;
      stray_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      orphan_q <= orphan_d;
      wd_q     <= wd_d;
      stray_q  <= stray_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      op_q     <= op_d;
    end
  end

  // Rotating search starting at rr_q; the first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    nxt       = 0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!win_found && bus.req_valid_i[GrantW'(idx)]) begin
        win_found = 1'b1;
        win_idx   = GrantW'(idx);
      end
    end
    nxt = int'(win_idx) + 1;
    if (nxt >= NumReq) nxt = 0;
    rr_next = GrantW'(nxt);
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    orphan_d = orphan_q;
    wd_d     = wd_q;
    stray_d  = stray_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    late_rsp = 1'b0;

    bus.req_ready_o      = '0;
    bus.resp_valid_o     = '0;
    bus.resp_data_o      = bus.dmi_resp_data_i;
    bus.resp_resp_o      = bus.dmi_resp_resp_i;
    bus.dmi_req_valid_o  = 1'b0;
    bus.dmi_resp_ready_o = 1'b1;
    timeout_o            = 1'b0;

    case (state_q)
      Idle: begin
        late_rsp = 1'b1;
        if (win_found) begin
          bus.req_ready_o[win_idx] = 1'b1;
          addr_d  = 7'(bus.req_addr_i >> (7 * int'(win_idx)));
          data_d  = 32'(bus.req_data_i >> (32 * int'(win_idx)));
          op_d    = 2'(bus.req_op_i >> (2 * int'(win_idx)));
          grant_d = win_idx;
          rr_d    = rr_next;
          state_d = Req;
        end
      end
      Req: begin
        late_rsp            = 1'b1;
        bus.dmi_req_valid_o = 1'b1;
        if (bus.dmi_req_ready_i) begin
          wd_d    = '0;
          state_d = Resp;
        end
      end
      Resp: begin
        if (orphan_q != 4'd0) begin
          // Leftover answer of a timed-out transaction: swallow it.
          if (bus.dmi_resp_valid_i) begin
            orphan_d = orphan_q - 4'd1;
            wd_d     = '0;
          end
        end else begin
          bus.resp_valid_o[grant_q] = bus.dmi_resp_valid_i;
          bus.dmi_resp_ready_o      = bus.resp_ready_i[grant_q];
          if (bus.dmi_resp_valid_i && bus.resp_ready_i[grant_q]) state_d = Idle;
        end
        if (!bus.dmi_resp_valid_i && TimeoutCycles != 0) begin
          if (wd_q == WdLast) begin
            timeout_o = 1'b1;
            if (orphan_q != 4'hf) orphan_d = orphan_q + 4'd1;
            wd_d    = '0;
            state_d = ErrResp;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      ErrResp: begin
        late_rsp                  = 1'b1;
        bus.resp_valid_o[grant_q] = 1'b1;
        bus.resp_data_o           = '0;
        bus.resp_resp_o           = 2'h2;
        if (bus.resp_ready_i[grant_q]) state_d = Idle;
      end
      default: state_d = Idle;
    endcase

    if (late_rsp && bus.dmi_resp_valid_i) begin
      if (orphan_q != 4'd0) orphan_d = orphan_q - 4'd1;
      else if (stray_q != 8'hff) stray_d = stray_q + 8'd1;
    end

    // Handshake outputs are held low for as long as reset is asserted.
    if (rst_i) begin
      bus.req_ready_o      = '0;
      bus.resp_valid_o     = '0;
      bus.dmi_req_valid_o  = 1'b0;
      bus.dmi_resp_ready_o = 1'b0;
      timeout_o            = 1'b0;
    end
  end

  assign bus.dmi_req_addr_o = addr_q;
  assign bus.dmi_req_data_o = data_q;
  assign bus.dmi_req_op_o   = op_q;
  assign busy_o             = (state_q != Idle);
  assign grant_o            = grant_q;
  assign stray_count_o      = stray_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// tb/tb_dmi_arbiter.sv - self-checking bench for dmi_arbiter with a round-robin reference model
module tb_dmi_arbiter;
  logic       clk;
  logic       rst;
  logic       busy;
  logic [0:0] grant;
  logic       timeout;
  logic [7:0] stray;

  dmi_arbiter_if #(.NumReq(2)) bus ();

  dmi_arbiter #(.NumReq(2), .TimeoutCycles(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus.slave),
    .busy_o       (busy),
    .grant_o      (grant),
    .timeout_o    (timeout),
    .stray_count_o(stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_ptr = 0;
  int          exp_stray = 0;
  logic [6:0]  tb_addr [2];
  logic [31:0] tb_data [2];
  logic [1:0]  tb_op   [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first valid requester in rotation order after the last grant.
  function automatic int exp_winner(input logic [1:0] mask);
    for (int k = 0; k < 2; k++) begin
      if (mask[(exp_ptr + k) % 2]) return (exp_ptr + k) % 2;
    end
    return -1;
  endfunction

  task automatic drive_payloads();
    bus.req_addr_i = {tb_addr[1], tb_addr[0]};
    bus.req_data_i = {tb_data[1], tb_data[0]};
    bus.req_op_i   = {tb_op[1], tb_op[0]};
  endtask

  task automatic random_payloads();
    for (int i = 0; i < 2; i++) begin
      tb_addr[i] = 7'($urandom);
      tb_data[i] = $urandom;
      tb_op[i]   = 2'($urandom);
    end
  endtask

  // Runs one transaction starting at a cycle where the arbiter is idle.
  task automatic do_txn(input logic [1:0] mask, input bit hold, input int req_dly, input int rsp_dly,
                        input int bp, input logic [31:0] rdata, input logic [1:0] rresp);
    int         w;
    logic [1:0] oh;
    @(negedge clk);
    bus.req_valid_i      = mask;
    drive_payloads();
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    bus.resp_ready_i     = 2'b11;
    w  = exp_winner(mask);
    oh = 2'b01 << w;
    #1;
    check("idle_busy", busy, 0);
    check("accept_ready", bus.req_ready_o, oh);
    exp_ptr = (w + 1) % 2;
    for (int c = 0; c <= req_dly; c++) begin
      @(negedge clk);
      if (!hold) bus.req_valid_i = 2'b00;
      bus.dmi_req_ready_i = (c == req_dly);
      #1;
      check("req_valid", bus.dmi_req_valid_o, 1);
      check("req_payload", {bus.dmi_req_addr_o, bus.dmi_req_data_o, bus.dmi_req_op_o},
            {tb_addr[w], tb_data[w], tb_op[w]});
      check("req_no_accept", bus.req_ready_o, 0);
      check("grant", grant, w);
    end
    for (int c = 0; c < rsp_dly; c++) begin
      @(negedge clk);
      bus.dmi_req_ready_i = 1'b0;
      #1;
      check("resp_wait_valid", bus.resp_valid_o, 0);
      check("resp_wait_busy", busy, 1);
    end
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      bus.dmi_req_ready_i  = 1'b0;
      bus.dmi_resp_valid_i = 1'b1;
      bus.dmi_resp_data_i  = rdata;
      bus.dmi_resp_resp_i  = rresp;
      bus.resp_ready_i     = ~oh;
      #1;
      check("bp_resp_valid", bus.resp_valid_o, oh);
      check("bp_dmi_ready", bus.dmi_resp_ready_o, 0);
      check("bp_no_accept", bus.req_ready_o, 0);
    end
    @(negedge clk);
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b1;
    bus.dmi_resp_data_i  = rdata;
    bus.dmi_resp_resp_i  = rresp;
    bus.resp_ready_i     = 2'b11;
    #1;
    check("resp_valid", bus.resp_valid_o, oh);
    check("resp_data", {bus.resp_data_o, bus.resp_resp_o}, {rdata, rresp});
    check("resp_dmi_ready", bus.dmi_resp_ready_o, 1);
    check("resp_timeout", timeout, 0);
  endtask

  initial begin
    int         w;
    logic [1:0] oh;
    rst = 1'b1;
    bus.req_valid_i      = 2'b11;
    bus.req_addr_i       = '0;
    bus.req_data_i       = '0;
    bus.req_op_i         = '0;
    bus.resp_ready_i     = 2'b11;
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b0;
    bus.dmi_resp_data_i  = '0;
    bus.dmi_resp_resp_i  = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", bus.req_ready_o, 0);
    check("rst_resp_valid", bus.resp_valid_o, 0);
    check("rst_dmi_req_valid", bus.dmi_req_valid_o, 0);
    check("rst_dmi_resp_ready", bus.dmi_resp_ready_o, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_timeout", timeout, 0);
    check("rst_stray", stray, 0);
    check("rst_req_payload", {bus.dmi_req_addr_o, bus.dmi_req_data_o, bus.dmi_req_op_o}, 0);
    bus.req_valid_i = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Fairness: both requesters valid throughout, grants must alternate 0,1,0,1.
    for (int t = 0; t < 4; t++) begin
      random_payloads();
      check("fair_order", exp_winner(2'b11), t % 2);
      do_txn(2'b11, 1'b1, t % 2, 1, 0, $urandom, 2'($urandom));
    end

    // Single requester read of 0x11, downstream ready after 3 cycles.
    random_payloads();
    tb_addr[0] = 7'h11;
    tb_op[0]   = 2'h1;
    do_txn(2'b01, 1'b0, 3, 1, 0, 32'hDEADBEEF, 2'h0);

    // Requester 1 holds off its response for 5 cycles while requester 0 waits.
    random_payloads();
    check("bp_expected_winner", exp_winner(2'b11), 1);
    do_txn(2'b11, 1'b1, 0, 0, 5, 32'hCAFEF00D, 2'h0);

    for (int t = 0; t < 30; t++) begin
      random_payloads();
      do_txn(2'($urandom_range(1, 3)), 1'b0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), $urandom, 2'($urandom));
    end

    // Watchdog: downstream accepts but never answers.
    random_payloads();
    @(negedge clk);
    bus.req_valid_i      = 2'b11;
    drive_payloads();
    bus.dmi_resp_valid_i = 1'b0;
    w  = exp_winner(2'b11);
    oh = 2'b01 << w;
    #1;
    check("to_accept", bus.req_ready_o, oh);
    exp_ptr = (w + 1) % 2;
    @(negedge clk);
    bus.req_valid_i     = 2'b00;
    bus.dmi_req_ready_i = 1'b1;
    #1;
    check("to_req_valid", bus.dmi_req_valid_o, 1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.dmi_req_ready_i = 1'b0;
      #1;
      check("to_pulse", timeout, (c == 7));
      check("to_no_resp", bus.resp_valid_o, 0);
    end
    @(negedge clk);
    bus.resp_ready_i = 2'b00;
    #1;
    check("err_valid", bus.resp_valid_o, oh);
    check("err_data", {bus.resp_data_o, bus.resp_resp_o}, {32'h0, 2'h2});
    check("err_timeout_once", timeout, 0);
    check("err_dmi_ready", bus.dmi_resp_ready_o, 1);
    @(negedge clk);
    bus.resp_ready_i = 2'b11;
    #1;
    check("err_hold", bus.resp_valid_o, oh);
    check("err_resp", bus.resp_resp_o, 2'h2);

    // Late answer of the timed-out transaction arrives while the next one is in Req.
    random_payloads();
    @(negedge clk);
    bus.req_valid_i = 2'b01;
    drive_payloads();
    w  = exp_winner(2'b01);
    oh = 2'b01 << w;
    #1;
    check("late_accept", bus.req_ready_o, oh);
    exp_ptr = (w + 1) % 2;
    @(negedge clk);
    bus.req_valid_i      = 2'b00;
    bus.dmi_resp_valid_i = 1'b1;
    bus.dmi_resp_data_i  = 32'h0BAD0BAD;
    #1;
    check("late_dmi_ready", bus.dmi_resp_ready_o, 1);
    check("late_not_fwd", bus.resp_valid_o, 0);
    check("late_req_valid", bus.dmi_req_valid_o, 1);
    @(negedge clk);
    bus.dmi_resp_valid_i = 1'b0;
    bus.dmi_req_ready_i  = 1'b1;
    #1;
    check("late_req_payload", {bus.dmi_req_addr_o, bus.dmi_req_data_o}, {tb_addr[w], tb_data[w]});
    @(negedge clk);
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_valid_i = 1'b1;
    bus.dmi_resp_data_i  = 32'h12345678;
    bus.dmi_resp_resp_i  = 2'h0;
    #1;
    check("late_real_valid", bus.resp_valid_o, oh);
    check("late_real_data", bus.resp_data_o, 32'h12345678);
    @(negedge clk);
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check("late_stray", stray, exp_stray);
    check("late_idle", busy, 0);

    // Stray response while idle with nothing outstanding.
    @(negedge clk);
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    check("stray_ready", bus.dmi_resp_ready_o, 1);
    check("stray_not_fwd", bus.resp_valid_o, 0);
    exp_stray++;
    @(negedge clk);
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check("stray_count", stray, exp_stray);

    // Reset asserted mid-Req.
    random_payloads();
    @(negedge clk);
    bus.req_valid_i = 2'b10;
    drive_payloads();
    @(negedge clk);
    #1;
    check("mid_req_valid", bus.dmi_req_valid_o, 1);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", bus.dmi_req_valid_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_req_ready", bus.req_ready_o, 0);
    check("mid_rst_stray", stray, 0);
    check("mid_rst_dmi_resp_ready", bus.dmi_resp_ready_o, 0);
    exp_ptr   = 0;
    exp_stray = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 2'b00;
    random_payloads();
    check("post_rst_winner", exp_winner(2'b11), 0);
    do_txn(2'b11, 1'b0, 1, 1, 0, $urandom, 2'h0);
    @(negedge clk);
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    check("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
